pixel_bus_arbiter: RTL and testbench

Shares the single pixel bus (x, y, color_draw, plot toward the VGA adapter; x, y address into the synchronous colour ROM, returning color_obs) between NREQ requesters such as the processor FSM, a screen-clear engine and a sprite engine. Round-robin arbitration with a valid/ready request handshake. Write requests plot one pixel; read requests fetch one ROM colour and return it on a per-requester response strobe. It sits between the requesters and the rom/VGA instances at system level.

---
 rtl/pixel_bus_pkg.sv | 23 ++
 rtl/pixel_bus_arbiter_rr_picker.sv | 34 +++
 rtl/pixel_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_pixel_bus_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_bus_pkg.sv
// Shared types and widths for the pixel bus arbiter.
// Optional grant locking is enabled by defining ARB_LOCK_EN.
package pixel_bus_pkg;

  localparam int XW       = 8;
  localparam int YW       = 8;
  localparam int CW       = 3;
  localparam int MAX_NREQ = 4;

  typedef enum logic [1:0] {
    ISSUE,
    RD_WAIT,
    RD_CAPTURE
  } state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] color;
    logic          we;
  } pix_req_t;

endpackage

// File: rtl/pixel_bus_arbiter_rr_picker.sv
// Combinational round-robin selector: the search starts one past
// last_grant; mask limits which requesters are eligible.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [NREQ-1:0] elig;
  logic [IW-1:0]   cand;

  always_comb begin
    elig = req & mask;
    gnt  = '0;
    idx  = last_grant;
    any  = 1'b0;
    cand = last_grant;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!any && elig[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/pixel_bus_arbiter.sv
// Round-robin arbiter sharing one pixel bus (VGA plot + colour ROM).
// Define ARB_LOCK_EN to let a requester hold its grant via req_lock.
module pixel_bus_arbiter
  import pixel_bus_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [XW*NREQ-1:0] req_x,
  input  logic [YW*NREQ-1:0] req_y,
  input  logic [CW*NREQ-1:0] req_color,
  input  logic [NREQ-1:0]    req_lock,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [CW-1:0]      rsp_color,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [CW-1:0]      color_draw,
  output logic               plot,
  input  logic [CW-1:0]      color_obs
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("pixel_bus_arbiter: NREQ out of range");
  end

  state_t          state, state_nxt;
  logic [IW-1:0]   last_grant, rd_id, pick_idx;
  logic [NREQ-1:0] pick_gnt, mask;
  logic            pick_any, accept;
  pix_req_t        sel;

`ifdef ARB_LOCK_EN
  logic          lock_act;
  logic [IW-1:0] lock_id;
  logic          sel_lock;

  always_comb begin
    mask = '1;
    if (lock_act) begin
      mask          = '0;
      mask[lock_id] = 1'b1;
    end
  end
`else
  logic lock_unused;
  assign lock_unused = ^req_lock;
  assign mask        = '1;
`endif

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req_valid),
    .mask       (mask),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    sel = '0;
`ifdef ARB_LOCK_EN
    sel_lock = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        sel.x     = req_x[i*XW +: XW];
        sel.y     = req_y[i*YW +: YW];
        sel.color = req_color[i*CW +: CW];
        sel.we    = req_we[i];
`ifdef ARB_LOCK_EN
        sel_lock  = req_lock[i];
`endif
      end
    end
  end

  assign accept = (state == ISSUE) && pick_any;

  always_ff @(posedge clk) begin
    if (reset) state <= ISSUE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    unique case (state)
      ISSUE: begin
        req_ready = pick_gnt;
        if (pick_any && !sel.we) state_nxt = RD_WAIT;
      end
      RD_WAIT:    state_nxt = RD_CAPTURE;
      RD_CAPTURE: state_nxt = ISSUE;
      default:    state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      color_draw <= '0;
      plot       <= 1'b0;
      rsp_valid  <= '0;
      rsp_color  <= '0;
      rd_id      <= '0;
      last_grant <= IW'(NREQ - 1);
`ifdef ARB_LOCK_EN
      lock_act   <= 1'b0;
      lock_id    <= '0;
`endif
    end else begin
      plot      <= 1'b0;
      rsp_valid <= '0;
      if (accept) begin
        last_grant <= pick_idx;
        x          <= sel.x;
        y          <= sel.y;
        if (sel.we) begin
          color_draw <= sel.color;
          plot       <= 1'b1;
        end else begin
          rd_id <= pick_idx;
        end
`ifdef ARB_LOCK_EN
        lock_act <= sel_lock;
        lock_id  <= pick_idx;
`endif
      end
      // ROM data for the read issued two cycles ago is on color_obs now
      if (state == RD_CAPTURE) begin
        rsp_color        <= color_obs;
        rsp_valid[rd_id] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_bus_arbiter.sv
// Directed bench for pixel_bus_arbiter with a synchronous ROM model.
// Lock expectations follow ARB_LOCK_EN.
module tb_pixel_bus_arbiter;

  localparam int NREQ = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_we = '0;
  logic [8*NREQ-1:0] req_x = '0;
  logic [8*NREQ-1:0] req_y = '0;
  logic [3*NREQ-1:0] req_color = '0;
  logic [NREQ-1:0] req_lock = '0;
  logic [NREQ-1:0] rsp_valid;
  logic [2:0]      rsp_color;
  logic [7:0]      x, y;
  logic [2:0]      color_draw;
  logic            plot;
  logic [2:0]      color_obs = '0;

  int errs = 0;
  int checks = 0;
  int g, n0;
  int exp_g[5];

  pixel_bus_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_color  (req_color),
    .req_lock   (req_lock),
    .rsp_valid  (rsp_valid),
    .rsp_color  (rsp_color),
    .x          (x),
    .y          (y),
    .color_draw (color_draw),
    .plot       (plot),
    .color_obs  (color_obs)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_f(logic [7:0] a, logic [7:0] b);
    return 3'(a * 8'd3 + b);
  endfunction

  always_ff @(posedge clk) color_obs <= rom_f(x, y);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic we, logic [7:0] xx,
                         logic [7:0] yy, logic [2:0] c);
    req_we[i]          = we;
    req_x[i*8 +: 8]    = xx;
    req_y[i*8 +: 8]    = yy;
    req_color[i*3 +: 3] = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick();
    tick();
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_col", 32'(color_draw), 0);
    check("rst_plot", 32'(plot), 0);
    check("rst_rspv", 32'(rsp_valid), 0);
    check("rst_rspc", 32'(rsp_color), 0);
    check("rst_rdy", 32'(req_ready), 0);
    reset = 1'b0;
    tick();

    // two writers, alternating grants
    set_req(0, 1'b1, 8'd10, 8'd20, 3'd3);
    set_req(1, 1'b1, 8'd30, 8'd40, 3'd5);
    req_valid = 2'b11;
    g = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("ww_rdy", 32'(req_ready), 32'(2'b01 << g));
      tick();
      check("ww_plot", 32'(plot), 1);
      check("ww_x", 32'(x), g ? 30 : 10);
      check("ww_y", 32'(y), g ? 40 : 20);
      check("ww_col", 32'(color_draw), g ? 5 : 3);
      g ^= 1;
    end
    req_valid = 2'b00;
    #1;
    check("idle_rdy", 32'(req_ready), 0);
    tick();
    check("idle_plot", 32'(plot), 0);
    check("idle_x", 32'(x), 30);

    // single read by req1 at (5,7), ROM value 6
    set_req(1, 1'b0, 8'd5, 8'd7, 3'd0);
    req_valid = 2'b10;
    #1;
    check("rd_rdy", 32'(req_ready), 2);
    tick();
    req_valid = 2'b00;
    check("rd_plot", 32'(plot), 0);
    check("rd_x", 32'(x), 5);
    check("rd_y", 32'(y), 7);
    check("rd_col", 32'(color_draw), 5);
    check("rd_rspv1", 32'(rsp_valid), 0);
    tick();
    check("rd_rspv2", 32'(rsp_valid), 0);
    tick();
    check("rd_rspv3", 32'(rsp_valid), 2);
    check("rd_rspc", 32'(rsp_color), 6);
    tick();
    check("rd_rspv4", 32'(rsp_valid), 0);

    // read by req0 with req1 write pending
    set_req(0, 1'b0, 8'd10, 8'd20, 3'd0);
    set_req(1, 1'b1, 8'd33, 8'd44, 3'd4);
    req_valid = 2'b11;
    #1;
    check("rw_rdy0", 32'(req_ready), 1);
    tick();
    req_valid = 2'b10;
    #1;
    check("rw_rdy1", 32'(req_ready), 0);
    check("rw_plot1", 32'(plot), 0);
    check("rw_x", 32'(x), 10);
    tick();
    check("rw_rdy2", 32'(req_ready), 0);
    check("rw_plot2", 32'(plot), 0);
    tick();
    check("rw_rspv", 32'(rsp_valid), 1);
    check("rw_rspc", 32'(rsp_color), 2);
    check("rw_rdy3", 32'(req_ready), 2);
    tick();
    req_valid = 2'b00;
    check("rw_plot3", 32'(plot), 1);
    check("rw_wx", 32'(x), 33);
    check("rw_wy", 32'(y), 44);
    check("rw_wcol", 32'(color_draw), 4);
    check("rw_rspv0", 32'(rsp_valid), 0);

    // lock sequence on req0 while req1 is waiting
`ifdef ARB_LOCK_EN
    exp_g = '{0, 0, 0, 0, 1};
`else
    exp_g = '{0, 1, 0, 1, 0};
`endif
    set_req(0, 1'b1, 8'd1, 8'd2, 3'd1);
    set_req(1, 1'b1, 8'd3, 8'd4, 3'd2);
    req_valid = 2'b11;
    n0 = 0;
    for (int k = 0; k < 5; k++) begin
      req_lock[0] = (n0 < 3);
      #1;
      check("lk_rdy", 32'(req_ready), 32'(2'b01 << exp_g[k]));
      tick();
      check("lk_x", 32'(x), exp_g[k] ? 3 : 1);
      if (exp_g[k] == 0) n0++;
    end
    req_valid = 2'b00;
    req_lock  = 2'b00;
    tick();

    // reset while a read sits in RD_WAIT
    set_req(0, 1'b0, 8'd9, 8'd9, 3'd0);
    req_valid = 2'b01;
    #1;
    check("rr_rdy", 32'(req_ready), 1);
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    tick();
    check("rr_x", 32'(x), 0);
    check("rr_y", 32'(y), 0);
    check("rr_col", 32'(color_draw), 0);
    check("rr_plot", 32'(plot), 0);
    check("rr_rspc", 32'(rsp_color), 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("rr_rspv", 32'(rsp_valid), 0);
      tick();
    end
    set_req(0, 1'b1, 8'd7, 8'd8, 3'd6);
    set_req(1, 1'b1, 8'd11, 8'd12, 3'd1);
    req_valid = 2'b11;
    #1;
    check("rr_first", 32'(req_ready), 1);
    tick();
    req_valid = 2'b00;
    check("rr_fx", 32'(x), 7);
    check("rr_fcol", 32'(color_draw), 6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
